// File: rtl/pri_rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, held until the owner drops its request.
// Define PRI_ARB_TIMEOUT_EN to force a release after MAX_HOLD grant cycles when others wait.
module pri_rr_arbiter #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] ptr, next_ptr, next_idx;
  logic [IDX_W-1:0] search_start, after_owner, win_idx, pos;
  logic [N-1:0]     next_gnt, search_req, owner_mask;
  logic             do_search, win_found, force_rel;

  generate
    if (N < 2 || IDX_W != $clog2(N) || CNT_W < $clog2(MAX_HOLD + 1)) begin : g_param_check
      $error("pri_rr_arbiter: inconsistent N/IDX_W/MAX_HOLD/CNT_W");
    end
  endgenerate

  assign owner_mask  = N'(1) << gnt_idx;
  assign after_owner = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;

  // A release (voluntary or forced) restarts the search just past the owner and excludes it.
  always_comb begin
    do_search    = 1'b0;
    search_start = ptr;
    search_req   = req;
    next_ptr     = ptr;
    if (state == IDLE) begin
      do_search = 1'b1;
    end else if (!req[gnt_idx] || force_rel) begin
      do_search    = 1'b1;
      search_start = after_owner;
      search_req   = req & ~owner_mask;
      next_ptr     = after_owner;
    end
  end

  // Descending offset scan so the lowest offset from search_start is the last to write win_idx.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    pos       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = IDX_W'((int'(search_start) + k) % N);
      if (search_req[pos]) begin
        win_found = 1'b1;
        win_idx   = pos;
      end
    end
  end

  always_comb begin
    next_state = state;
    next_gnt   = gnt;
    next_idx   = gnt_idx;
    if (do_search) begin
      if (win_found) begin
        next_state = GRANT;
        next_gnt   = N'(1) << win_idx;
        next_idx   = win_idx;
      end else begin
        next_state = IDLE;
        next_gnt   = '0;
        next_idx   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= next_state;
      ptr       <= next_ptr;
      gnt       <= next_gnt;
      gnt_idx   <= next_idx;
      gnt_valid <= |next_gnt;
    end
  end

`ifdef PRI_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;

  // Forced release only when someone else is waiting; a lone owner keeps the grant.
  assign force_rel = (state == GRANT) && req[gnt_idx] &&
                     (hold_cnt == CNT_W'(MAX_HOLD - 1)) && |(req & ~owner_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= force_rel;
      if (next_state == IDLE || (do_search && win_found))
        hold_cnt <= '0;
      else if (hold_cnt != CNT_W'(MAX_HOLD))
        hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_pri_rr_arbiter.sv
// Randomized scoreboard bench for pri_rr_arbiter against a cycle-level rotation model.
// Honours PRI_ARB_TIMEOUT_EN the same way as the design.
module tb_pri_rr_arbiter;

  localparam int N        = 8;
  localparam int IDX_W    = 3;
  localparam int MAX_HOLD = 16;
  localparam int CNT_W    = 5;
`ifdef PRI_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct {
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] idx;
    logic             valid;
    logic             tmo;
    int               cyc;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Model state: owner is -1 when idle, hold counts completed grant edges.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;

  pri_rr_arbiter #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t zero_exp();
    exp_t e;
    e.gnt = '0; e.idx = '0; e.valid = 1'b0; e.tmo = 1'b0; e.cyc = cyc;
    return e;
  endfunction

  task automatic checkOutput(input string name, input exp_t e);
    n_cmp++;
    if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== e.valid || timeout !== e.tmo) begin
      n_err++;
      $display("[TB] FAIL %s: got gnt=%h idx=%0d valid=%b timeout=%b, expected gnt=%h idx=%0d valid=%b timeout=%b",
               name, gnt, gnt_idx, gnt_valid, timeout, e.gnt, e.idx, e.valid, e.tmo);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
  endtask

  // One clock edge of the arbitration rules, expressed on integers.
  task automatic model_step(input logic [N-1:0] r, output exp_t e);
    bit search = 1'b0;
    bit tmo    = 1'b0;
    int start  = m_ptr;
    int excl   = -1;
    if (m_owner < 0) begin
      search = 1'b1;
    end else begin
      bit others = 1'b0;
      for (int i = 0; i < N; i++)
        if (i != m_owner && r[i]) others = 1'b1;
      if (!r[m_owner] || (TMO_EN && m_hold == MAX_HOLD - 1 && others)) begin
        tmo    = r[m_owner];
        m_ptr  = (m_owner + 1) % N;
        start  = m_ptr;
        excl   = m_owner;
        search = 1'b1;
      end else if (m_hold < MAX_HOLD) begin
        m_hold++;
      end
    end
    if (search) begin
      m_owner = -1;
      m_hold  = 0;
      for (int k = 0; k < N; k++) begin
        int i = (start + k) % N;
        if (m_owner < 0 && i != excl && r[i]) m_owner = i;
      end
    end
    e       = zero_exp();
    e.tmo   = TMO_EN && tmo;
    if (m_owner >= 0) begin
      e.gnt[m_owner] = 1'b1;
      e.idx          = IDX_W'(m_owner);
      e.valid        = 1'b1;
    end
  endtask

  // Called just after the value on req has been set; covers exactly one rising edge.
  task automatic step_edge();
    exp_t e;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      model_reset();
      e = zero_exp();
    end else begin
      model_step(req, e);
      e.cyc = cyc;
    end
    sb_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [N-1:0] v);
    @(negedge clk);
    req = v;
    step_edge();
  endtask

  // Monitor: compares every scheduled expectation one time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput($sformatf("cycle%0d", e.cyc), e);
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    rst_n = 1'b0;
    req   = 8'hFF;
    #1;
    checkOutput("reset_t0", zero_exp());
    repeat (3) applyStimulus(8'hFF);

    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'b1000_0001;
    step_edge();
    applyStimulus(8'b1000_0000);
    applyStimulus(8'b1000_0100);
    applyStimulus(8'b0000_0100);

    applyStimulus(8'hFF);
    for (int i = 0; i < 10; i++) applyStimulus(8'hFF & ~(8'(1) << m_owner));

    applyStimulus(8'h00);
    applyStimulus(8'h08);
    for (int i = 0; i < 36; i++) applyStimulus(8'h28);

    applyStimulus(8'h10);
    applyStimulus(8'h10);
    applyStimulus(8'h10);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset", zero_exp());
    model_reset();
    applyStimulus(8'h11);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'h11;
    step_edge();
    applyStimulus(8'h10);

    r = 8'h10;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 19))
        0:       r = '0;
        1:       r = 8'($urandom());
        2, 3, 4,
        5, 6, 7: r[$urandom_range(0, N - 1)] ^= 1'b1;
        default: ;
      endcase
      applyStimulus(r);
    end

    @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
